pipeline_stall_ctrl: RTL and testbench

- Responder to the hazard detector's stall requests and to the memory/branch/halt events of the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Turns those requests into per-stage-register enable and flush controls.
- Holds the multi-cycle bubble counter, so the hazard detector can be purely combinational and state-free.
- Sits in the datapath top beside the pipeline latches, whose enable and flush pins it drives.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 46 ++++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 33 +++
 rtl/pipeline_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline control types: stall FSM states, default widths and the
// bundled per-stage-register enable/flush controls used by the datapath.
package pipeline_stall_ctrl_pkg;

    localparam int BUBW_DEF = 2;
    localparam int CNTW_DEF = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } stall_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } pipe_ctrl_t;

    // Free-running pipeline: every latch loads, nothing is flushed.
    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c.pc_en       = 1'b1;
        c.ifid_en     = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_en     = 1'b1;
        c.idex_flush  = 1'b0;
        c.exmem_en    = 1'b1;
        c.exmem_flush = 1'b0;
        c.memwb_en    = 1'b1;
        return c;
    endfunction

    // Whole pipeline frozen: nothing loads, nothing is flushed.
    function automatic pipe_ctrl_t ctrl_freeze();
        pipe_ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one when asked, unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: turns hazard, memory, branch, jump and halt
// events into enable/flush controls for PC and the four pipeline latches,
// and owns the multi-cycle bubble counter so hazard detection stays stateless.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int BUBW = BUBW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            HazReq,
    input  logic [BUBW-1:0] HazLen,
    input  logic            ihit,
    input  logic            MemReq,
    input  logic            dhit,
    input  logic            BranchEX,
    input  logic            JumpID,
    input  logic            HaltMEM,
    output logic            PCEn,
    output logic            IFIDEn,
    output logic            IFIDFlush,
    output logic            IDEXEn,
    output logic            IDEXFlush,
    output logic            EXMEMEn,
    output logic            EXMEMFlush,
    output logic            MEMWBEn,
    output logic            Halted,
    output logic [CNTW-1:0] StallCnt
);

    stall_state_t    state_q;
    stall_state_t    state_d;
    logic [BUBW-1:0] bub_cnt_q;
    logic [BUBW-1:0] bub_cnt_d;
    logic            halted_q;
    logic            halted_d;
    pipe_ctrl_t      ctrl;
    logic            dstall;
    logic            stall_inc;

    assign dstall = MemReq & ~dhit;

    // Priority decode of pipeline events into latch controls and next FSM state.
    always_comb begin
        ctrl      = ctrl_run();
        state_d   = state_q;
        bub_cnt_d = bub_cnt_q;

        if (state_q == HALT) begin
            ctrl = ctrl_freeze();
        end else if (dstall) begin
            ctrl = ctrl_freeze();
        end else if (HaltMEM) begin
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            state_d          = HALT;
            bub_cnt_d        = '0;
        end else if (BranchEX) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            state_d         = RUN;
            bub_cnt_d       = '0;
        end else if (state_q == BUBBLE) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
            if (bub_cnt_q <= BUBW'(1)) begin
                state_d   = RUN;
                bub_cnt_d = '0;
            end else begin
                bub_cnt_d = bub_cnt_q - BUBW'(1);
            end
        end else if (HazReq && (HazLen != '0)) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
            if (HazLen != BUBW'(1)) begin
                state_d   = BUBBLE;
                bub_cnt_d = HazLen - BUBW'(1);
            end
        end else if (JumpID) begin
            ctrl.ifid_flush = 1'b1;
        end else if (!ihit) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
        end

        halted_d = (state_d == HALT);
    end

    // FSM state, remaining-bubble counter and registered halt flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RUN;
            bub_cnt_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bub_cnt_q <= bub_cnt_d;
            halted_q  <= halted_d;
        end
    end

    assign stall_inc = ~ctrl.pc_en & (state_q != HALT);

    sat_counter #(
        .W(CNTW)
    ) u_stall_cnt (
        .clk  (CLK),
        .rst  (RST),
        .inc  (stall_inc),
        .count(StallCnt)
    );

    assign PCEn       = ctrl.pc_en;
    assign IFIDEn     = ctrl.ifid_en;
    assign IFIDFlush  = ctrl.ifid_flush;
    assign IDEXEn     = ctrl.idex_en;
    assign IDEXFlush  = ctrl.idex_flush;
    assign EXMEMEn    = ctrl.exmem_en;
    assign EXMEMFlush = ctrl.exmem_flush;
    assign MEMWBEn    = ctrl.memwb_en;
    assign Halted     = halted_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios with
// literal expectations plus a per-cycle comparison against an event model.
module tb_pipeline_stall_ctrl;

    localparam int BUBW    = 2;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    localparam int EV_NONE    = 0;
    localparam int EV_HALTED  = 1;
    localparam int EV_DSTALL  = 2;
    localparam int EV_HALTMEM = 3;
    localparam int EV_BRANCH  = 4;
    localparam int EV_BUBBLE  = 5;
    localparam int EV_JUMP    = 6;
    localparam int EV_MISS    = 7;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            HazReq = 1'b0;
    logic [BUBW-1:0] HazLen = '0;
    logic            ihit = 1'b1;
    logic            MemReq = 1'b0;
    logic            dhit = 1'b0;
    logic            BranchEX = 1'b0;
    logic            JumpID = 1'b0;
    logic            HaltMEM = 1'b0;
    logic            PCEn;
    logic            IFIDEn;
    logic            IFIDFlush;
    logic            IDEXEn;
    logic            IDEXFlush;
    logic            EXMEMEn;
    logic            EXMEMFlush;
    logic            MEMWBEn;
    logic            Halted;
    logic [CNTW-1:0] StallCnt;

    int checks = 0;
    int errors = 0;

    // Model state: halted flag, bubbles still owed after this one, stall count.
    bit m_halted  = 1'b0;
    int m_pending = 0;
    int m_cnt     = 0;

    pipeline_stall_ctrl #(
        .BUBW(BUBW),
        .CNTW(CNTW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .HazReq    (HazReq),
        .HazLen    (HazLen),
        .ihit      (ihit),
        .MemReq    (MemReq),
        .dhit      (dhit),
        .BranchEX  (BranchEX),
        .JumpID    (JumpID),
        .HaltMEM   (HaltMEM),
        .PCEn      (PCEn),
        .IFIDEn    (IFIDEn),
        .IFIDFlush (IFIDFlush),
        .IDEXEn    (IDEXEn),
        .IDEXFlush (IDEXFlush),
        .EXMEMEn   (EXMEMEn),
        .EXMEMFlush(EXMEMFlush),
        .MEMWBEn   (MEMWBEn),
        .Halted    (Halted),
        .StallCnt  (StallCnt)
    );

    always #5 CLK = ~CLK;

    // Which event governs this cycle, highest priority first.
    function automatic int modelEvent();
        if (m_halted) return EV_HALTED;
        if (MemReq && !dhit) return EV_DSTALL;
        if (HaltMEM) return EV_HALTMEM;
        if (BranchEX) return EV_BRANCH;
        if (m_pending > 0 || (HazReq && HazLen != 0)) return EV_BUBBLE;
        if (JumpID) return EV_JUMP;
        if (!ihit) return EV_MISS;
        return EV_NONE;
    endfunction

    // Controls {PCEn,IFIDEn,IFIDFlush,IDEXEn,IDEXFlush,EXMEMEn,EXMEMFlush,MEMWBEn}.
    function automatic logic [7:0] modelCtrl(input int ev);
        case (ev)
            EV_HALTED, EV_DSTALL: return 8'b0000_0000;
            EV_HALTMEM:           return 8'b0010_1011;
            EV_BRANCH:            return 8'b1010_1101;
            EV_BUBBLE:            return 8'b0000_1101;
            EV_JUMP:              return 8'b1011_0101;
            EV_MISS:              return 8'b0011_0101;
            default:              return 8'b1101_0101;
        endcase
    endfunction

    // A latch enable is irrelevant while that latch is being flushed.
    function automatic logic [7:0] careMask(input logic [7:0] e);
        logic [7:0] m;
        m = 8'hFF;
        if (e[5]) m[6] = 1'b0;
        if (e[3]) m[4] = 1'b0;
        if (e[1]) m[2] = 1'b0;
        return m;
    endfunction

    // Advance the model on each clock edge; reset clears it at once.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_halted  = 1'b0;
            m_pending = 0;
            m_cnt     = 0;
        end else begin
            int ev;
            logic [7:0] e;
            ev = modelEvent();
            e  = modelCtrl(ev);
            if (!e[7] && !m_halted && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            case (ev)
                EV_HALTMEM: m_halted = 1'b1;
                EV_BRANCH:  m_pending = 0;
                EV_BUBBLE: begin
                    if (m_pending > 0) m_pending = m_pending - 1;
                    else m_pending = int'(HazLen) - 1;
                end
                default: ;
            endcase
        end
    end

    // Mid-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        logic [7:0] e;
        logic [7:0] m;
        logic [7:0] a;
        e = modelCtrl(modelEvent());
        m = careMask(e);
        a = {PCEn, IFIDEn, IFIDFlush, IDEXEn, IDEXFlush, EXMEMEn, EXMEMFlush, MEMWBEn};
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("[TB] FAIL model_ctrl t=%0t got %b expected %b (care %b)", $time, a, e, m);
        end
        checks++;
        if (Halted !== m_halted) begin
            errors++;
            $display("[TB] FAIL model_halted t=%0t got %b expected %b", $time, Halted, m_halted);
        end
        checks++;
        if (StallCnt !== CNTW'(m_cnt)) begin
            errors++;
            $display("[TB] FAIL model_stallcnt t=%0t got %0d expected %0d", $time, StallCnt, m_cnt);
        end
    end

    task automatic applyStimulus(input logic haz, input logic [BUBW-1:0] len, input logic ih,
                                 input logic mreq, input logic dh, input logic br,
                                 input logic jmp, input logic hlt);
        HazReq   = haz;
        HazLen   = len;
        ihit     = ih;
        MemReq   = mreq;
        dhit     = dh;
        BranchEX = br;
        JumpID   = jmp;
        HaltMEM  = hlt;
    endtask

    task automatic checkOutput(input string name, input logic [CNTW-1:0] actual,
                               input logic [CNTW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic midCycle();
        @(negedge CLK);
    endtask

    task automatic endCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Idle after reset
        idle();
        midCycle();
        checkOutput("idle_pcen", CNTW'(PCEn), 1);
        checkOutput("idle_ifidflush", CNTW'(IFIDFlush), 0);
        checkOutput("idle_halted", CNTW'(Halted), 0);
        checkOutput("idle_stallcnt", StallCnt, 0);
        endCycle();

        // Single load-use bubble
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        midCycle();
        checkOutput("lu_pcen", CNTW'(PCEn), 0);
        checkOutput("lu_ifiden", CNTW'(IFIDEn), 0);
        checkOutput("lu_idexflush", CNTW'(IDEXFlush), 1);
        endCycle();
        idle();
        midCycle();
        checkOutput("lu_after_pcen", CNTW'(PCEn), 1);
        checkOutput("lu_stallcnt", StallCnt, 1);
        endCycle();

        // Two bubbles with a three-cycle data stall in between (adds 5)
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            midCycle();
            checkOutput("ds_all_en", CNTW'({PCEn, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn}), 0);
            endCycle();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        midCycle();
        checkOutput("ds_bubble2_pcen", CNTW'(PCEn), 0);
        checkOutput("ds_bubble2_idexflush", CNTW'(IDEXFlush), 1);
        endCycle();
        idle();
        midCycle();
        checkOutput("ds_after_pcen", CNTW'(PCEn), 1);
        checkOutput("ds_stallcnt", StallCnt, 6);
        endCycle();

        // Branch aborts a three-bubble sequence in its second cycle
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        midCycle();
        checkOutput("br_pcen", CNTW'(PCEn), 1);
        checkOutput("br_flushes", CNTW'({IFIDFlush, IDEXFlush}), 3);
        endCycle();
        idle();
        midCycle();
        checkOutput("br_after_en", CNTW'({PCEn, IFIDEn, IDEXEn, EXMEMEn}), 15);
        checkOutput("br_stallcnt", StallCnt, 7);
        endCycle();

        // Fetch miss with jump, then fetch miss alone
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        midCycle();
        checkOutput("jmp_pcen", CNTW'(PCEn), 1);
        checkOutput("jmp_ifidflush", CNTW'(IFIDFlush), 1);
        endCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        midCycle();
        checkOutput("miss_pcen", CNTW'(PCEn), 0);
        checkOutput("miss_ifidflush", CNTW'(IFIDFlush), 1);
        checkOutput("miss_idexen", CNTW'(IDEXEn), 1);
        endCycle();

        // Hazard during fetch miss: hold ID, no IF/ID flush
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        midCycle();
        checkOutput("hazmiss_ifiden", CNTW'(IFIDEn), 0);
        checkOutput("hazmiss_ifidflush", CNTW'(IFIDFlush), 0);
        endCycle();

        // Halt, ten frozen cycles, then asynchronous reset
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        midCycle();
        checkOutput("halt_memwben", CNTW'(MEMWBEn), 1);
        checkOutput("halt_exmemflush", CNTW'(EXMEMFlush), 1);
        checkOutput("halt_halted_early", CNTW'(Halted), 0);
        endCycle();
        idle();
        for (int i = 0; i < 10; i++) begin
            midCycle();
            checkOutput("halted_flag", CNTW'(Halted), 1);
            checkOutput("halted_all_en", CNTW'({PCEn, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn}), 0);
            endCycle();
        end
        checkOutput("halted_stallcnt", StallCnt, 10);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("rst_halted", CNTW'(Halted), 0);
        checkOutput("rst_stallcnt", StallCnt, 0);
        checkOutput("rst_pcen", CNTW'(PCEn), 1);
        endCycle();
        RST = 1'b0;

        // Saturation of the stall counter under a long fetch miss
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) endCycle();
        idle();
        midCycle();
        checkOutput("sat_stallcnt", StallCnt, 15);
        endCycle();
        endCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
